regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
// - Shares the register file's single write port between NUM_REQ writeback sources (e.g. ALU and load unit).
// - Round-robin arbitration, valid/ready handshake per source, one registered write per cycle.
// - Sits between the writeback stage and register_file; drives its write_control input.
// PARAMETERS
// - NUM_REQ   2   number of writeback requesters; legal range 2..8
// - IDX_W     $clog2(NUM_REQ)   grant index width; derived, never overridden
// PORTS
// - clock          in   1             core clock; all state updates on posedge
// - reset          in   1             synchronous, active-high
// - req_valid      in   NUM_REQ       requester i has a write pending
// - req_ready      out  NUM_REQ       requester i accepted this cycle (one-hot or zero)
// - req_rd         in   NUM_REQ x 5   rv_reg_t destination per requester
// - req_value      in   NUM_REQ x XLEN  write data per requester
// - wr_stall       in   1             write port reserved this cycle; no grants made
// - write_control  out  reg_write_control_t  registered {enable, which_register, value} to register_file
// - grant_idx      out  IDX_W         index of the requester granted in the previous cycle (valid when write_control.enable)
// BEHAVIOUR
// - Reset: write_control all-zero, grant_idx=0, rr pointer=0 (requester 0 highest priority next); req_ready=0 during reset.
// - Grant (combinational): if !wr_stall && !reset, grant lowest i in rotated order starting at rr pointer with req_valid[i]; req_ready[i]=1 for it only.
// - Handshake: transfer when req_valid[i] && req_ready[i]; requester must hold valid/rd/value stable until ready; arbiter never drops a valid.
// - Latency: transfer in cycle t -> write_control.enable=1 with that rd/value for exactly cycle t+1 -> regfile commits at edge ending t+1.
// - No transfer in cycle t -> write_control.enable=0 in t+1; which_register/value cleared to 0 (no stale data on port).
// - rr pointer: after grant to i, pointer <= (i+1) mod NUM_REQ; unchanged when no grant; wraps from NUM_REQ-1 to 0.
// - Fairness: all requesters continuously valid -> grants strictly rotate; max wait NUM_REQ-1 cycles absent wr_stall.
// - x0: request with rd==0 is accepted (ready=1, pointer advances) but produces enable=0 in t+1.
// - wr_stall=1: req_ready=0, pointer held; output register still shows the transfer from the previous cycle.
// - Reset mid-operation: write captured in the cycle before reset is discarded (enable=0 after reset edge).
// - One write per cycle max; no internal queueing beyond the single output register.
// CONFIGURATION
// - Macro WB_ARB_FWD_EN: adds ports fwd_rs1/fwd_rs2 (in, rv_reg_t) and fwd_rs1_val/fwd_rs2_val (out, XLEN), fwd_rs1_hit/fwd_rs2_hit (out, 1).
// - With it: hit=1 and val=write_control.value when write_control.enable && which_register==fwd_rsN (rsN!=0); else hit=0, val=0. Purely combinational off the output register.
// - Without it: those ports and logic absent; decode stage relies on stalling for the in-flight write.
// STRUCTURE
// - Shared core package: XLEN, rv_reg_t, reg_write_control_t (existing); add wb_req_t {rv_reg_t rd; logic [XLEN-1:0] value;}.
// - Sub-module rr_priority_picker #(N): combinational rotate-and-find-first: inputs req mask + pointer, outputs one-hot grant + index + any.
// - Top level holds rr pointer, output register, optional forwarding compare.
// TESTING
// - Reset, then idle: write_control.enable=0, which_register=0, value=0 every cycle; req_ready=0.
// - Only req 1 valid, rd=5, value=0xDEADBEEF at t: req_ready=2'b10 at t; enable=1, rd=5, value=0xDEADBEEF at t+1 only.
// - Both valid continuously, 6 cycles: grants 0,1,0,1,0,1; each write appears one cycle after its ready.
// - Req 0 rd=0 value=0x1234: accepted (ready=1), next cycle enable=0; pointer advances so req 1 wins a following tie.
// - wr_stall=1 for 3 cycles with both valid: req_ready=0 throughout, pointer unchanged, grant resumes with prior-priority requester.
// - Grant at t then reset at t+1 edge: enable=0 after reset; with WB_ARB_FWD_EN, fwd_rs1=rd of in-flight write -> hit=1, value matches; rs1=0 -> hit=0.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Core register-file types shared by the writeback path and register_file.
// Defines the write-port control word and the per-requester writeback payload.
package regfile_write_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] rv_reg_t;

  typedef struct packed {
    logic            enable;
    rv_reg_t         which_register;
    logic [XLEN-1:0] value;
  } reg_write_control_t;

  typedef struct packed {
    rv_reg_t         rd;
    logic [XLEN-1:0] value;
  } wb_req_t;

  // x0 is hard-wired zero, so it never matches an in-flight write.
  function automatic logic fwd_match(input reg_write_control_t wc, input rv_reg_t rs);
    return wc.enable && (rs != '0) && (wc.which_register == rs);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_priority_picker.sv
// Combinational rotate-and-find-first: picks the first set request at or after
// the pointer position, wrapping modulo N. Outputs one-hot grant, index and any.
module rr_priority_picker #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from farthest to nearest so the nearest valid request wins last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[rot(i_ptr, k)]) begin
        o_idx = rot(i_ptr, k);
        o_any = 1'b1;
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NUM_REQ
// writeback sources. Optional feature macro WB_ARB_FWD_EN adds operand forwarding.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  rv_reg_t [NUM_REQ-1:0]            req_rd,
  input  logic [NUM_REQ-1:0][XLEN-1:0]     req_value,
  input  logic                             wr_stall,
  output reg_write_control_t               write_control,
  output logic [IDX_W-1:0]                 grant_idx
`ifdef WB_ARB_FWD_EN
  ,
  input  rv_reg_t                          fwd_rs1,
  input  rv_reg_t                          fwd_rs2,
  output logic [XLEN-1:0]                  fwd_rs1_val,
  output logic [XLEN-1:0]                  fwd_rs2_val,
  output logic                             fwd_rs1_hit,
  output logic                             fwd_rs2_hit
`endif
);

  logic [NUM_REQ-1:0] w_mask_p0;
  logic [NUM_REQ-1:0] w_grant_p0;
  logic [IDX_W-1:0]   w_idx_p0;
  logic               vld_p0;
  wb_req_t            w_req_p0 [NUM_REQ];
  wb_req_t            w_sel_p0;

  logic [IDX_W-1:0]   r_ptr;
  reg_write_control_t r_wc_p1;
  logic [IDX_W-1:0]   r_gidx_p1;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Stage p0: arbitration over the live requests.
  assign w_mask_p0 = (wr_stall || reset) ? '0 : req_valid;

  rr_priority_picker #(.N(NUM_REQ)) u_picker (
    .i_req   (w_mask_p0),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_p0),
    .o_idx   (w_idx_p0),
    .o_any   (vld_p0)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_p0[i].rd    = req_rd[i];
      w_req_p0[i].value = req_value[i];
    end
    w_sel_p0 = w_req_p0[w_idx_p0];
  end

  assign req_ready = w_grant_p0;

  // Stage p1: registered write port; x0 writes are accepted but never enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr     <= '0;
      r_gidx_p1 <= '0;
      r_wc_p1   <= '0;
    end else begin
      if (vld_p0) begin
        r_ptr     <= ptr_after(w_idx_p0);
        r_gidx_p1 <= w_idx_p0;
      end
      if (vld_p0 && (w_sel_p0.rd != '0)) begin
        r_wc_p1.enable         <= 1'b1;
        r_wc_p1.which_register <= w_sel_p0.rd;
        r_wc_p1.value          <= w_sel_p0.value;
      end else begin
        r_wc_p1 <= '0;
      end
    end
  end

  assign write_control = r_wc_p1;
  assign grant_idx     = r_gidx_p1;

`ifdef WB_ARB_FWD_EN
  always_comb begin
    fwd_rs1_hit = fwd_match(r_wc_p1, fwd_rs1);
    fwd_rs2_hit = fwd_match(r_wc_p1, fwd_rs2);
    fwd_rs1_val = fwd_rs1_hit ? r_wc_p1.value : '0;
    fwd_rs2_val = fwd_rs2_hit ? r_wc_p1.value : '0;
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NUM_REQ=2) with hand-computed expectations;
// forwarding checks are included when WB_ARB_FWD_EN is defined.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  rv_reg_t [1:0]            req_rd;
  logic [1:0][XLEN-1:0]     req_value;
  logic                     wr_stall;
  reg_write_control_t       write_control;
  logic [0:0]               grant_idx;
`ifdef WB_ARB_FWD_EN
  rv_reg_t                  fwd_rs1, fwd_rs2;
  logic [XLEN-1:0]          fwd_rs1_val, fwd_rs2_val;
  logic                     fwd_rs1_hit, fwd_rs2_hit;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.NUM_REQ(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rd        (req_rd),
    .req_value     (req_value),
    .wr_stall      (wr_stall),
    .write_control (write_control),
    .grant_idx     (grant_idx)
`ifdef WB_ARB_FWD_EN
    ,
    .fwd_rs1       (fwd_rs1),
    .fwd_rs2       (fwd_rs2),
    .fwd_rs1_val   (fwd_rs1_val),
    .fwd_rs2_val   (fwd_rs2_val),
    .fwd_rs1_hit   (fwd_rs1_hit),
    .fwd_rs2_hit   (fwd_rs2_hit)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_wc(input string tag, input logic en, input logic [4:0] rd,
                          input logic [31:0] val);
    check_eq({tag, ".en"},  64'(write_control.enable),         64'(en));
    check_eq({tag, ".rd"},  64'(write_control.which_register), 64'(rd));
    check_eq({tag, ".val"}, 64'(write_control.value),          64'(val));
  endtask

  initial begin
    reset     = 1'b1;
    wr_stall  = 1'b0;
    req_valid = 2'b11;
    req_rd[0] = 5'd3;  req_value[0] = 32'h0000_00A0;
    req_rd[1] = 5'd7;  req_value[1] = 32'h0000_00B1;
`ifdef WB_ARB_FWD_EN
    fwd_rs1 = '0;
    fwd_rs2 = '0;
`endif

    // Reset held: no grants even with requests present.
    cycle();
    check_eq("rst_ready", 64'(req_ready), 64'(2'b00));
    cycle();
    check_wc("rst_wc", 1'b0, 5'd0, 32'h0);
    check_eq("rst_gidx", 64'(grant_idx), 64'd0);
    reset     = 1'b0;
    req_valid = 2'b00;

    // Idle.
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_wc("idle_wc", 1'b0, 5'd0, 32'h0);
      check_eq("idle_ready", 64'(req_ready), 64'(2'b00));
    end

    // Single requester 1.
    req_valid = 2'b10; req_rd[1] = 5'd5; req_value[1] = 32'hDEAD_BEEF;
    #1 check_eq("single_ready", 64'(req_ready), 64'(2'b10));
    cycle();
    req_valid = 2'b00;
    check_wc("single_wc", 1'b1, 5'd5, 32'hDEAD_BEEF);
    check_eq("single_gidx", 64'(grant_idx), 64'd1);
    cycle();
    check_wc("single_clear", 1'b0, 5'd0, 32'h0);

    // Both continuously valid: grants 0,1,0,1,0,1.
    req_rd[1] = 5'd7; req_value[1] = 32'h0000_00B1;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1 check_eq("rr_ready", 64'(req_ready), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
      if (k > 0) begin
        if ((k - 1) % 2 == 0) check_wc("rr_wc", 1'b1, 5'd3, 32'h0000_00A0);
        else                  check_wc("rr_wc", 1'b1, 5'd7, 32'h0000_00B1);
      end
      cycle();
    end
    req_valid = 2'b00;
    check_wc("rr_last_wc", 1'b1, 5'd7, 32'h0000_00B1);
    check_eq("rr_last_gidx", 64'(grant_idx), 64'd1);
    cycle();

    // x0 write: accepted, no enable, pointer advances.
    req_valid = 2'b01; req_rd[0] = 5'd0; req_value[0] = 32'h0000_1234;
    #1 check_eq("x0_ready", 64'(req_ready), 64'(2'b01));
    cycle();
    check_wc("x0_wc", 1'b0, 5'd0, 32'h0);
    check_eq("x0_gidx", 64'(grant_idx), 64'd0);
    req_rd[0] = 5'd3; req_value[0] = 32'h0000_00A0;
    req_valid = 2'b11;
    #1 check_eq("x0_tie_ready", 64'(req_ready), 64'(2'b10));
    cycle();

    // Stall for 3 cycles with both valid; pointer points at requester 0.
    wr_stall = 1'b1;
    #1 check_eq("stall_ready0", 64'(req_ready), 64'(2'b00));
    check_wc("stall_prev_wc", 1'b1, 5'd7, 32'h0000_00B1);
    cycle();
    check_eq("stall_ready1", 64'(req_ready), 64'(2'b00));
    check_wc("stall_wc1", 1'b0, 5'd0, 32'h0);
    cycle();
    check_eq("stall_ready2", 64'(req_ready), 64'(2'b00));
    check_wc("stall_wc2", 1'b0, 5'd0, 32'h0);
    cycle();
    wr_stall = 1'b0;
    #1 check_eq("unstall_ready", 64'(req_ready), 64'(2'b01));
    check_wc("stall_wc3", 1'b0, 5'd0, 32'h0);
    cycle();
    req_valid = 2'b00;
    check_wc("unstall_wc", 1'b1, 5'd3, 32'h0000_00A0);
    check_eq("unstall_gidx", 64'(grant_idx), 64'd0);
    cycle();

    // Grant to 0 (pointer -> 1), then reset discards the in-flight write.
    req_valid = 2'b01; req_rd[0] = 5'd9; req_value[0] = 32'h0000_55AA;
    #1 check_eq("mid_ready", 64'(req_ready), 64'(2'b01));
    cycle();
    req_valid = 2'b00;
    check_wc("mid_wc", 1'b1, 5'd9, 32'h0000_55AA);
`ifdef WB_ARB_FWD_EN
    fwd_rs1 = 5'd9; fwd_rs2 = 5'd0;
    #1;
    check_eq("fwd1_hit", 64'(fwd_rs1_hit), 64'd1);
    check_eq("fwd1_val", 64'(fwd_rs1_val), 64'h55AA);
    check_eq("fwd2_x0_hit", 64'(fwd_rs2_hit), 64'd0);
    check_eq("fwd2_x0_val", 64'(fwd_rs2_val), 64'd0);
    fwd_rs1 = 5'd4; fwd_rs2 = 5'd9;
    #1;
    check_eq("fwd1_miss_hit", 64'(fwd_rs1_hit), 64'd0);
    check_eq("fwd1_miss_val", 64'(fwd_rs1_val), 64'd0);
    check_eq("fwd2_hit", 64'(fwd_rs2_hit), 64'd1);
    check_eq("fwd2_val", 64'(fwd_rs2_val), 64'h55AA);
    fwd_rs1 = 5'd9;
`endif
    reset = 1'b1;
    cycle();
    check_wc("mid_rst_wc", 1'b0, 5'd0, 32'h0);
    check_eq("mid_rst_gidx", 64'(grant_idx), 64'd0);
`ifdef WB_ARB_FWD_EN
    check_eq("fwd_rst_hit", 64'(fwd_rs1_hit), 64'd0);
`endif
    reset     = 1'b0;
    req_valid = 2'b11;
    #1 check_eq("post_rst_ready", 64'(req_ready), 64'(2'b01));
    cycle();
    req_valid = 2'b00;
    check_wc("post_rst_wc", 1'b1, 5'd9, 32'h0000_55AA);
    check_eq("post_rst_gidx", 64'(grant_idx), 64'd0);
    cycle();
    check_wc("final_idle_wc", 1'b0, 5'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
